// File: rtl/pipe_types.sv
// pipe_types: shared state encoding and IF/ID payload layout for pipeline stage registers
// IF/ID payload is packed as {instr, pc} with pc in the low PC_W bits.
package pipe_types;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t;
  localparam int INSTR_W = 192;
  localparam int PC_W = 32;
  localparam int IFID_WIDTH = INSTR_W + PC_W;
  function automatic logic [IFID_WIDTH-1:0] pack_ifid(input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] pc);
    return {instr, pc};
  endfunction
endpackage

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: handshake FSM for pipe_stage_reg, drives in_ready/out_valid and datapath load enables
// Ports: clk, rst (async active-low), flush, in_valid, out_ready in;
//        in_ready, out_valid, load_main, sel_skid (main takes skid), load_skid out.
module pipe_stage_ctrl import pipe_types::*; #(
  parameter int SKID = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main,
  output logic sel_skid,
  output logic load_skid
);
  pipe_state_t state, next;
  logic in_xfer;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EMPTY;
    else state <= next;
  always_comb begin
    in_ready = SKID != 0 ? state != FULL : state == EMPTY || out_ready;
    out_valid = state != EMPTY;
    in_xfer = in_valid && in_ready;
    next = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    sel_skid = 1'b0;
    if (SKID == 0) begin
      load_main = in_ready;
      next = in_ready ? (in_valid ? BUSY : EMPTY) : state;
    end else begin
      case (state)
        EMPTY: begin
          load_main = in_xfer;
          next = in_xfer ? BUSY : EMPTY;
        end
        BUSY: begin
          load_main = in_xfer && out_ready;
          load_skid = in_xfer && !out_ready;
          next = in_xfer ? (out_ready ? BUSY : FULL) : (out_ready ? EMPTY : BUSY);
        end
        FULL: begin
          load_main = out_ready;
          sel_skid = 1'b1;
          next = out_ready ? BUSY : FULL;
        end
        default: next = EMPTY;
      endcase
    end
    if (flush) next = EMPTY;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register, optional 2-entry skid buffer
// Ports: clk, rst (async active-low), flush (sync squash), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream, stall_cnt/xfer_cnt perf counters.
// Macro PIPE_STAGE_PERF_EN enables the saturating counters; otherwise they read 0.
module pipe_stage_reg import pipe_types::*; #(
  parameter int WIDTH = IFID_WIDTH,
  parameter int SKID = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      xfer_cnt
);
  logic [WIDTH-1:0] main_q, skid_q;
  logic load_main, sel_skid, load_skid;
  pipe_stage_ctrl #(.SKID(SKID)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .out_ready(out_ready),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .load_main(load_main),
    .sel_skid(sel_skid),
    .load_skid(load_skid)
  );
  // zero payload on flush doubles as the NOP bubble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= sel_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  assign out_data = main_q;
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
      if (out_valid && out_ready && !(&xfer_cnt)) xfer_cnt <= xfer_cnt + 32'd1;
    end
`else
  assign stall_cnt = '0;
  assign xfer_cnt = '0;
`endif
endmodule
